// File: rtl/axis_gen_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream port among N_SRC sources (ARB_TID_TAG_EN: M_TID carries source index).
// Latency: 1 cycle grant in IDLE, then 1 cycle source-to-output through a registered stage; >=1 idle cycle between packets.
// Backpressure: granted source's TREADY = ~M_TVALID | M_TREADY (combinational); output fields held while stalled.
module axis_gen_arbiter #(
    parameter int N_SRC  = 4,
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       ENABLE,
    input  logic [N_SRC-1:0]           S_TVALID,
    output logic [N_SRC-1:0]           S_TREADY,
    input  logic [N_SRC*TDATAW-1:0]    S_TDATA,
    input  logic [N_SRC-1:0]           S_TLAST,
    input  logic [N_SRC*TIDW-1:0]      S_TID,
    input  logic [N_SRC*TDESTW-1:0]    S_TDEST,
    output logic                       M_TVALID,
    input  logic                       M_TREADY,
    output logic [TDATAW-1:0]          M_TDATA,
    output logic                       M_TLAST,
    output logic [TIDW-1:0]            M_TID,
    output logic [TDESTW-1:0]          M_TDEST,
    output logic [$clog2(N_SRC)-1:0]   GRANT_O,
    output logic                       BUSY_O
);

    localparam int GW = $clog2(N_SRC);
    localparam logic [GW:0] NSW = (GW+1)'(N_SRC);

    typedef enum logic {IDLE, PKT} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, last_grant_q;
    logic [GW-1:0]   pick, off;
    logic [GW:0]     sum;
    logic [N_SRC-1:0] rot;
    logic            pick_vld;
    logic            out_free;
    logic            accept;
    logic            accept_last;
    logic            arb_fire;

    logic [TDATAW-1:0] sel_dat;
    logic [TIDW-1:0]   sel_tid;
    logic [TDESTW-1:0] sel_dest;
    logic              sel_last;

    // Rotate requests so bit 0 is the source right after last_grant; lowest set bit wins.
    always_comb begin
        rot = N_SRC'({S_TVALID, S_TVALID} >> ({1'b0, last_grant_q} + 1'b1));
        off = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (rot[j]) off = GW'(j);
        end
        sum      = {1'b0, last_grant_q} + {{GW{1'b0}}, 1'b1} + {1'b0, off};
        pick     = (sum >= NSW) ? GW'(sum - NSW) : sum[GW-1:0];
        pick_vld = |S_TVALID;
    end

    assign out_free    = ~M_TVALID | M_TREADY;
    assign accept      = (state_q == PKT) && S_TVALID[gnt_q] && out_free;
    assign sel_last    = S_TLAST[gnt_q];
    assign accept_last = accept && sel_last;
    assign arb_fire    = (state_q == IDLE) && ENABLE && pick_vld;

    assign sel_dat  = S_TDATA[gnt_q*TDATAW +: TDATAW];
    assign sel_dest = S_TDEST[gnt_q*TDESTW +: TDESTW];
`ifdef ARB_TID_TAG_EN
    assign sel_tid  = TIDW'(gnt_q);
`else
    assign sel_tid  = S_TID[gnt_q*TIDW +: TIDW];
`endif

    always_comb begin
        S_TREADY = '0;
        if (state_q == PKT) S_TREADY[gnt_q] = out_free;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (arb_fire)    state_d = PKT;
            PKT:  if (accept_last) state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            last_grant_q <= GW'(N_SRC - 1);
        end else begin
            state_q <= state_d;
            if (arb_fire)    gnt_q        <= pick;
            if (accept_last) last_grant_q <= gnt_q;
        end
    end

    // Output register: a new load wins over the drain of the previous beat.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            M_TVALID <= 1'b0;
            M_TDATA  <= '0;
            M_TLAST  <= 1'b0;
            M_TID    <= '0;
            M_TDEST  <= '0;
        end else if (accept) begin
            M_TVALID <= 1'b1;
            M_TDATA  <= sel_dat;
            M_TLAST  <= sel_last;
            M_TID    <= sel_tid;
            M_TDEST  <= sel_dest;
        end else if (M_TREADY) begin
            M_TVALID <= 1'b0;
        end
    end

    assign GRANT_O = gnt_q;
    assign BUSY_O  = (state_q == PKT);

endmodule

// File: tb/tb_axis_gen_arbiter.sv
// Directed bench for axis_gen_arbiter: per-source beat tables feed the ports, output handshakes are logged.
module tb_axis_gen_arbiter;

    logic         CLK;
    logic         RST_N;
    logic         ENABLE;
    logic [3:0]   S_TVALID;
    logic [3:0]   S_TREADY;
    logic [127:0] S_TDATA;
    logic [3:0]   S_TLAST;
    logic [7:0]   S_TID;
    logic [15:0]  S_TDEST;
    logic         M_TVALID;
    logic         M_TREADY;
    logic [31:0]  M_TDATA;
    logic         M_TLAST;
    logic [1:0]   M_TID;
    logic [3:0]   M_TDEST;
    logic [1:0]   GRANT_O;
    logic         BUSY_O;

    axis_gen_arbiter #(.N_SRC(4), .TDATAW(32), .TDESTW(4), .TIDW(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE),
        .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
        .S_TLAST(S_TLAST), .S_TID(S_TID), .S_TDEST(S_TDEST),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
        .M_TLAST(M_TLAST), .M_TID(M_TID), .M_TDEST(M_TDEST),
        .GRANT_O(GRANT_O), .BUSY_O(BUSY_O)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [32:0] mem [4][16];
    int          head [4];
    int          tail [4];
    logic [3:0]  en_src;
    logic [1:0]  tid_cfg [4];
    logic [3:0]  hs;
    logic [32:0] out_log [64];
    int          n_out;
    logic [31:0] e2 [10];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_tid(input int s);
`ifdef ARB_TID_TAG_EN
        return 2'(s);
`else
        return tid_cfg[s];
`endif
    endfunction

    task automatic push(input int s, input logic [31:0] d, input logic l);
        mem[s][tail[s]] = {l, d};
        tail[s]++;
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        en_src = 4'b0000;
        n_out  = 0;
    endtask

    // Drive sources from their tables, note handshakes, advance one clock, pop accepted beats.
    task automatic tick();
        for (int i = 0; i < 4; i++) begin
            S_TVALID[i]          = en_src[i] && (head[i] != tail[i]);
            S_TDATA[i*32 +: 32]  = (head[i] != tail[i]) ? mem[i][head[i]][31:0] : 32'h0;
            S_TLAST[i]           = (head[i] != tail[i]) ? mem[i][head[i]][32] : 1'b0;
            S_TID[i*2 +: 2]      = tid_cfg[i];
            S_TDEST[i*4 +: 4]    = 4'(i);
        end
        #1;
        hs = S_TVALID & S_TREADY;
        if (M_TVALID && M_TREADY && n_out < 64) begin
            out_log[n_out] = {M_TLAST, M_TDATA};
            n_out++;
        end
        @(posedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 4; i++) if (hs[i]) head[i]++;
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int c = 0;
        while (n_out < target && c < budget) begin
            tick();
            c++;
        end
        check(tag, 64'(n_out), 64'(target));
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        clear_src();
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tid_cfg[0] = 2'd1; tid_cfg[1] = 2'd2; tid_cfg[2] = 2'd3; tid_cfg[3] = 2'd0;
        e2[0] = 32'h000; e2[1] = 32'h001; e2[2] = 32'h100; e2[3] = 32'h101;
        e2[4] = 32'h200; e2[5] = 32'h201; e2[6] = 32'h300; e2[7] = 32'h301;
        e2[8] = 32'h010; e2[9] = 32'h011;
        RST_N = 1'b0; ENABLE = 1'b1; M_TREADY = 1'b1;
        S_TVALID = '0; S_TDATA = '0; S_TLAST = '0; S_TID = '0; S_TDEST = '0;
        clear_src();

        // Reset values
        repeat (2) @(negedge CLK);
        check("rst_mvalid", 64'(M_TVALID), 0);
        check("rst_mlast",  64'(M_TLAST), 0);
        check("rst_mdata",  64'(M_TDATA), 0);
        check("rst_busy",   64'(BUSY_O), 0);
        check("rst_grant",  64'(GRANT_O), 0);
        check("rst_sready", 64'(S_TREADY), 0);
        RST_N = 1'b1;

        // Single source, 3-beat packet
        en_src = 4'b0001;
        push(0, 32'h11, 1'b0); push(0, 32'h22, 1'b0); push(0, 32'h33, 1'b1);
        tick();
        check("t1_busy",   64'(BUSY_O), 1);
        check("t1_grant",  64'(GRANT_O), 0);
        check("t1_mvalid0", 64'(M_TVALID), 0);
        check("t1_sready", 64'(S_TREADY), 64'h1);
        tick();
        check("t1_mvalid1", 64'(M_TVALID), 1);
        check("t1_d0",     64'(M_TDATA), 64'h11);
        check("t1_l0",     64'(M_TLAST), 0);
        check("t1_tid",    64'(M_TID), 64'(exp_tid(0)));
        check("t1_dest",   64'(M_TDEST), 0);
        tick();
        check("t1_d1",     64'(M_TDATA), 64'h22);
        check("t1_l1",     64'(M_TLAST), 0);
        tick();
        check("t1_d2",     64'(M_TDATA), 64'h33);
        check("t1_l2",     64'(M_TLAST), 1);
        check("t1_busy_end", 64'(BUSY_O), 0);
        tick();
        check("t1_drain",  64'(M_TVALID), 0);
        check("t1_count",  64'(n_out), 3);

        // Four sources continuously valid, 2-beat packets
        do_reset();
        en_src = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            push(i, 32'h100 * i, 1'b0);
            push(i, 32'h100 * i + 1, 1'b1);
        end
        push(0, 32'h010, 1'b0); push(0, 32'h011, 1'b1);
        run_until("rr_count", 10, 60);
        for (int k = 0; k < 10; k++)
            check($sformatf("rr_beat%0d", k), 64'(out_log[k]), 64'({(k % 2 == 1), e2[k]}));

        // Backpressure on source 2
        do_reset();
        en_src = 4'b0100;
        push(2, 32'h5A, 1'b0); push(2, 32'hA5, 1'b0); push(2, 32'h3C, 1'b1);
        tick(); tick(); tick();
        check("bp_load", 64'(M_TDATA), 64'hA5);
        M_TREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_hold_d%0d", k), 64'(M_TDATA), 64'hA5);
            check($sformatf("bp_hold_v%0d", k), 64'(M_TVALID), 1);
            check($sformatf("bp_sready%0d", k), 64'(S_TREADY), 0);
        end
        M_TREADY = 1'b1;
        tick();
        check("bp_next_d", 64'(M_TDATA), 64'h3C);
        check("bp_next_l", 64'(M_TLAST), 1);
        tick();
        check("bp_count", 64'(n_out), 3);
        check("bp_b0", 64'(out_log[0]), {1'b0, 32'h5A});
        check("bp_b1", 64'(out_log[1]), {1'b0, 32'hA5});
        check("bp_b2", 64'(out_log[2]), {1'b1, 32'h3C});

        // ENABLE gating with sources 1 and 3
        do_reset();
        ENABLE = 1'b0;
        en_src = 4'b1010;
        for (int k = 0; k < 4; k++) push(1, 32'h1000 + k, (k == 3));
        push(3, 32'h3000, 1'b0); push(3, 32'h3001, 1'b1);
        tick(); tick(); tick();
        check("en_busy",   64'(BUSY_O), 0);
        check("en_sready", 64'(S_TREADY), 0);
        check("en_mvalid", 64'(M_TVALID), 0);
        ENABLE = 1'b1;
        tick();
        check("en_grant",  64'(GRANT_O), 1);
        check("en_busy1",  64'(BUSY_O), 1);
        tick();
        check("en_d0",     64'(M_TDATA), 64'h1000);
        check("en_tid",    64'(M_TID), 64'(exp_tid(1)));
        check("en_dest",   64'(M_TDEST), 1);
        ENABLE = 1'b0;
        tick();
        check("en_d1",     64'(M_TDATA), 64'h1001);
        tick();
        check("en_d2",     64'(M_TDATA), 64'h1002);
        tick();
        check("en_d3",     64'(M_TDATA), 64'h1003);
        check("en_last",   64'(M_TLAST), 1);
        check("en_idle",   64'(BUSY_O), 0);
        tick(); tick();
        check("en_hold_idle",  64'(BUSY_O), 0);
        check("en_hold_grant", 64'(GRANT_O), 1);
        ENABLE = 1'b1;
        run_until("en_count", 6, 20);
        for (int k = 0; k < 4; k++)
            check($sformatf("en_b%0d", k), 64'(out_log[k]), 64'({(k == 3), 32'h1000 + k}));
        check("en_b4", 64'(out_log[4]), {1'b0, 32'h3000});
        check("en_b5", 64'(out_log[5]), {1'b1, 32'h3001});

        // Reset in the middle of a packet
        do_reset();
        en_src = 4'b0110;
        push(1, 32'h51, 1'b1);
        for (int k = 0; k < 4; k++) push(2, 32'h61 + k, (k == 3));
        tick();
        check("mr_grant1", 64'(GRANT_O), 1);
        tick();
        tick();
        check("mr_grant2", 64'(GRANT_O), 2);
        check("mr_busy",   64'(BUSY_O), 1);
        tick();
        check("mr_mvalid", 64'(M_TVALID), 1);
        check("mr_d0",     64'(M_TDATA), 64'h61);
        RST_N = 1'b0;
        #1;
        check("mr_clr_v",     64'(M_TVALID), 0);
        check("mr_clr_l",     64'(M_TLAST), 0);
        check("mr_clr_d",     64'(M_TDATA), 0);
        check("mr_clr_id",    64'(M_TID), 0);
        check("mr_clr_dest",  64'(M_TDEST), 0);
        check("mr_clr_busy",  64'(BUSY_O), 0);
        check("mr_clr_grant", 64'(GRANT_O), 0);
        check("mr_clr_srdy",  64'(S_TREADY), 0);
        clear_src();
        tick(); tick();
        RST_N = 1'b1;
        en_src = 4'b1111;
        for (int i = 0; i < 4; i++) push(i, 32'h70 + i, 1'b1);
        tick();
        check("mr_regrant", 64'(GRANT_O), 0);
        check("mr_rebusy",  64'(BUSY_O), 1);
        tick();
        check("mr_first_d", 64'(M_TDATA), 64'h70);
        check("mr_first_l", 64'(M_TLAST), 1);

        // TID from source 3
        do_reset();
        en_src = 4'b1000;
        push(3, 32'h3333, 1'b1);
        tick(); tick();
        check("tid_data", 64'(M_TDATA), 64'h3333);
        check("tid_val",  64'(M_TID), 64'(exp_tid(3)));
        check("tid_dest", 64'(M_TDEST), 3);
        tick();
        check("tid_drain", 64'(M_TVALID), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_gen_arbiter.md
Name: axis_gen_arbiter

Overview:
- Packet-level round-robin arbiter that shares one NoC AXI-Stream injection port between N_SRC traffic-generator masters.
- Each num_gen-style source drives its own slave port. The arbiter grants one source at a time and holds that grant until the source's TLAST beat is accepted.
- Accepted beats pass through a single registered output stage to the router input.

Parameters:
N_SRC, 4, number of requesting sources (2..8)
TDATAW, 32, AXIS data width
TDESTW, 4, AXIS dest width
TIDW, 2, AXIS id width; must be >= clog2(N_SRC) when ARB_TID_TAG_EN is defined

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
ENABLE  in  1  allow new arbitration; an in-flight packet always completes
S_TVALID  in  N_SRC  per-source valid
S_TREADY  out  N_SRC  per-source ready
S_TDATA  in  N_SRC*TDATAW  source i at bits [i*TDATAW +: TDATAW]
S_TLAST  in  N_SRC  per-source last
S_TID  in  N_SRC*TIDW  packed ids, source i at [i*TIDW +: TIDW]
S_TDEST  in  N_SRC*TDESTW  packed dests, source i at [i*TDESTW +: TDESTW]
M_TVALID  out  1  registered valid
M_TREADY  in  1  downstream ready
M_TDATA  out  TDATAW  registered data
M_TLAST  out  1  registered last
M_TID  out  TIDW  registered id
M_TDEST  out  TDESTW  registered dest
GRANT_O  out  clog2(N_SRC)  index of the current/last granted source
BUSY_O  out  1  high while in state PKT

Behaviour:
- Reset (async, RST_N low):
  - State is IDLE.
  - M_TVALID, M_TLAST, M_TDATA, M_TID, M_TDEST, BUSY_O are 0; S_TREADY is all 0.
  - Round-robin pointer last_grant = N_SRC-1, so source 0 has first priority. GRANT_O = 0.
- FSM states: IDLE and PKT.
- IDLE:
  - If ENABLE and |S_TVALID: pick the first valid source scanning last_grant+1, last_grant+2, ... modulo N_SRC.
  - Register the pick into gnt, set GRANT_O = gnt, go to PKT.
  - No beat is transferred in IDLE. S_TREADY is all 0.
  - Grant latency is 1 cycle from the first valid request.
- PKT:
  - S_TREADY[gnt] = (~M_TVALID | M_TREADY). This is combinational from M_TREADY. All other S_TREADY bits are 0.
  - On S_TVALID[gnt] & S_TREADY[gnt]: output register loads data/last/id/dest of source gnt and M_TVALID <= 1.
  - If the accepted beat has TLAST: last_grant <= gnt, go to IDLE.
  - If S_TVALID[gnt] drops mid-packet: hold the grant and insert bubbles; no timeout.
- Output stage:
  - If M_TVALID & M_TREADY and no new load in the same cycle, M_TVALID <= 0.
  - Output fields are held stable while M_TVALID & ~M_TREADY.
  - Source-to-output latency is 1 cycle; throughput is 1 beat/cycle within a packet.
- Packet boundaries:
  - At least 1 idle arbitration cycle between packets (PKT->IDLE->PKT), so max utilisation is L/(L+1) for L-beat packets.
  - A single-beat packet (TLAST on first beat) is legal and returns to IDLE immediately.
- ENABLE:
  - ENABLE low in IDLE: stay in IDLE.
  - ENABLE low in PKT: no effect until TLAST is accepted.
- Simultaneous requests are resolved purely by rotation. Source i is never starved if it holds valid: it waits at most N_SRC-1 packets.
- A requester whose valid drops before the arbitration cycle loses nothing; it is re-evaluated next IDLE.
- Reset mid-packet: the packet is truncated, the output clears immediately, and no TLAST is emitted.

Optional Feature:
- Macro: ARB_TID_TAG_EN.
- Defined: M_TID is loaded with {zero-extend, gnt}, i.e. the source index, instead of S_TID. Sink can identify the origin without generator cooperation.
- Undefined: M_TID = S_TID of the granted source, passed through unchanged.

Test Plan:
- Single-source packet: source 0 only, 3-beat packet 0x11,0x22,0x33 (TLAST on 0x33), M_TREADY=1.
  - M_TVALID rises 2 cycles after S_TVALID[0] (grant + register), beats in order, M_TLAST only with 0x33.
  - GRANT_O=0; BUSY_O low 1 cycle after the last accept.
- All four sources valid continuously, 2-beat packets.
  - Grant order 0,1,2,3,0. No interleaving of beats across sources; each M_TLAST is followed by the next source's data.
- Backpressure: M_TREADY low for 5 cycles mid-packet from source 2 with data 0xA5.
  - M_TDATA holds 0xA5 and M_TVALID stays 1; S_TREADY[2] stays 0 while the output is full.
  - No beat lost or duplicated.
- ENABLE low with sources 1 and 3 valid.
  - No grant, all S_TREADY 0. Raise ENABLE: source 1 granted first.
  - Drop ENABLE mid-packet: the packet still completes with TLAST.
- Assert RST_N low mid-packet (after 1 of 4 beats).
  - All outputs 0 immediately. After release, source 0 wins if all sources are valid.
- With ARB_TID_TAG_EN defined: source 3 sends S_TID=0 -> M_TID=3.
  - Without the macro: M_TID=0.
